npc_bpu: RTL and testbench

- Parametrised next-PC generator with an integrated branch prediction unit for the IF stage.
- Owns the fetch PC register and a direct-mapped branch target buffer (BTB). Each BTB entry holds a 2-bit saturating counter.
- Predicts the next fetch address each cycle. Accepts resolved branch/jump outcomes from EX, trains the BTB, and redirects fetch and flushes younger stages on a misprediction.

---
 rtl/npc_bpu_if.sv | 32 +++
 rtl/npc_bpu.sv | 108 ++++++++++
 tb/tb_npc_bpu.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_bpu_if.sv
// Fetch-side bundle between the next-PC/branch-predictor block and the pipeline:
// EX resolution inputs and stall in, fetch PC and prediction out.
interface npc_bpu_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            ex_valid;
    logic            ex_is_br;
    logic            ex_is_jmp;
    logic            ex_taken;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            flush;

    modport master (
        output stall, ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pc, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pc, pc4, pred_taken, pred_target, flush
    );

    modport slave (
        input  stall, ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pc, ex_target,
               ex_pred_taken, ex_pred_target,
        output pc, pc4, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/npc_bpu.sv
// Fetch PC register with a direct-mapped BTB of 2-bit saturating counters.
// Predicts the next fetch address and repairs fetch when EX resolves a misprediction.
module npc_bpu #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic        clk,
    input  logic        rst,
    npc_bpu_if.slave    bus
);
    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic [XLEN-1:0] pc_q, pc_d;

    logic            valid_q [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q   [BTB_ENTRIES];
    logic [XLEN-1:0] tgt_q   [BTB_ENTRIES];
    logic            jmp_q   [BTB_ENTRIES];
    logic [1:0]      cnt_q   [BTB_ENTRIES];

    logic [IDX-1:0]  fIdx, exIdx;
    logic [TAGW-1:0] fTag, exTag;
    logic            fHit, exHit;
    logic            predTaken;
    logic [XLEN-1:0] pc4, predTarget;
    logic            ctrl, actTaken, mispredict;
    logic [XLEN-1:0] redirect;
    logic [1:0]      cntNext;

    // Lookup reads the pre-update BTB contents; same-index writes land at the edge.
    always_comb begin
        fIdx       = pc_q[IDX+1:2];
        fTag       = pc_q[XLEN-1:IDX+2];
        pc4        = pc_q + FOUR;
        fHit       = valid_q[fIdx] && (tag_q[fIdx] == fTag);
        predTaken  = fHit && (jmp_q[fIdx] || cnt_q[fIdx][1]);
        predTarget = predTaken ? tgt_q[fIdx] : pc4;
    end

    always_comb begin
        exIdx      = bus.ex_pc[IDX+1:2];
        exTag      = bus.ex_pc[XLEN-1:IDX+2];
        exHit      = valid_q[exIdx] && (tag_q[exIdx] == exTag);
        ctrl       = bus.ex_is_br || bus.ex_is_jmp;
        actTaken   = bus.ex_is_jmp || (bus.ex_is_br && bus.ex_taken);
        mispredict = bus.ex_valid &&
                     ((ctrl && (actTaken != bus.ex_pred_taken)) ||
                      (ctrl && actTaken && bus.ex_pred_taken &&
                       (bus.ex_target != bus.ex_pred_target)) ||
                      (!ctrl && bus.ex_pred_taken));
        redirect   = actTaken ? bus.ex_target : bus.ex_pc + FOUR;
        cntNext    = cnt_q[exIdx];
        if (actTaken) begin
            if (cnt_q[exIdx] != 2'b11) cntNext = cnt_q[exIdx] + 2'b01;
        end else begin
            if (cnt_q[exIdx] != 2'b00) cntNext = cnt_q[exIdx] - 2'b01;
        end
    end

    // A misprediction repairs fetch even while the front end is stalled.
    always_comb begin
        pc_d = predTarget;
        if (mispredict) pc_d = redirect;
        else if (bus.stall) pc_d = pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    // Tags, targets and jump bits are only meaningful behind a valid bit, so they skip reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (bus.ex_valid) begin
            if (ctrl) begin
                if (exHit) begin
                    cnt_q[exIdx] <= cntNext;
                    if (actTaken) begin
                        tgt_q[exIdx] <= bus.ex_target;
                        jmp_q[exIdx] <= bus.ex_is_jmp;
                    end
                end else if (actTaken) begin
                    valid_q[exIdx] <= 1'b1;
                    tag_q[exIdx]   <= exTag;
                    tgt_q[exIdx]   <= bus.ex_target;
                    jmp_q[exIdx]   <= bus.ex_is_jmp;
                    cnt_q[exIdx]   <= 2'b10;
                end
            end else if (bus.ex_pred_taken) begin
                valid_q[exIdx] <= 1'b0;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.pred_taken  = predTaken;
    assign bus.pred_target = predTarget;
    assign bus.flush       = mispredict;
endmodule

// File: tb/tb_npc_bpu.sv
// Bench for npc_bpu: directed scenarios plus a randomized run, all checked
// against a table-based predictor model kept in the bench.
module tb_npc_bpu;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    npc_bpu_if #(.XLEN(32)) bus ();

    npc_bpu #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one record per table slot, slot = (addr/4) mod 16, tag = addr/64.
    logic [31:0] mPc;
    bit          mValid [16];
    logic [31:0] mTag   [16];
    logic [31:0] mTgt   [16];
    bit          mJmp   [16];
    int          mCnt   [16];

    function automatic int slotOf(logic [31:0] a);
        return int'((a >> 2) % 32'd16);
    endfunction

    function automatic bit expPredTaken();
        int s = slotOf(mPc);
        return mValid[s] && (mTag[s] == (mPc >> 6)) && (mJmp[s] || mCnt[s] >= 2);
    endfunction

    function automatic logic [31:0] expPredTarget();
        return expPredTaken() ? mTgt[slotOf(mPc)] : mPc + 32'd4;
    endfunction

    function automatic bit expMispredict();
        bit act  = bus.ex_is_jmp || (bus.ex_is_br && bus.ex_taken);
        bit ctrl = bus.ex_is_br || bus.ex_is_jmp;
        if (!bus.ex_valid) return 1'b0;
        if (!ctrl) return bus.ex_pred_taken;
        if (act != bus.ex_pred_taken) return 1'b1;
        return act && (bus.ex_target != bus.ex_pred_target);
    endfunction

    task automatic modelReset();
        mPc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mCnt[i]   = 1;
        end
    endtask

    // Advance one clock edge and let the model absorb the inputs seen at that edge.
    task automatic tick();
        bit          act, ctrl, mp;
        logic [31:0] nxt;
        int          s;
        @(posedge clk);
        act  = bus.ex_is_jmp || (bus.ex_is_br && bus.ex_taken);
        ctrl = bus.ex_is_br || bus.ex_is_jmp;
        mp   = expMispredict();
        if (rst) begin
            modelReset();
        end else begin
            if (mp) nxt = act ? bus.ex_target : bus.ex_pc + 32'd4;
            else if (bus.stall) nxt = mPc;
            else nxt = expPredTarget();
            s = slotOf(bus.ex_pc);
            if (bus.ex_valid && ctrl) begin
                if (mValid[s] && mTag[s] == (bus.ex_pc >> 6)) begin
                    mCnt[s] = act ? ((mCnt[s] < 3) ? mCnt[s] + 1 : 3) : ((mCnt[s] > 0) ? mCnt[s] - 1 : 0);
                    if (act) begin
                        mTgt[s] = bus.ex_target;
                        mJmp[s] = bus.ex_is_jmp;
                    end
                end else if (act) begin
                    mValid[s] = 1'b1;
                    mTag[s]   = bus.ex_pc >> 6;
                    mTgt[s]   = bus.ex_target;
                    mJmp[s]   = bus.ex_is_jmp;
                    mCnt[s]   = 2;
                end
            end else if (bus.ex_valid && bus.ex_pred_taken) begin
                mValid[s] = 1'b0;
            end
            mPc = nxt;
        end
        #1;
    endtask

    task automatic applyEx(bit v, bit br, bit jmp, bit tk, logic [31:0] epc,
                           logic [31:0] tgt, bit pt, logic [31:0] ptgt);
        bus.ex_valid       = v;
        bus.ex_is_br       = br;
        bus.ex_is_jmp      = jmp;
        bus.ex_taken       = tk;
        bus.ex_pc          = epc;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
        #1;
    endtask

    task automatic idleEx();
        applyEx(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    // Steer fetch to an address via a mispredicted jump from an otherwise unused slot.
    task automatic redirectTo(logic [31:0] a);
        applyEx(1, 0, 1, 0, 32'h3F0, a, 0, 32'h0);
        tick();
        idleEx();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        idleEx();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.pred_taken !== 1'b0 || bus.flush !== 1'b0 || bus.pred_target !== 32'h4) begin
            errors++;
            $display("[TB] FAIL reset_state: pc=%h pt=%b ptgt=%h flush=%b, expected 0/0/4/0",
                     bus.pc, bus.pred_taken, bus.pred_target, bus.flush);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'(4 * i) || bus.pred_taken !== 1'b0 || bus.flush !== 1'b0) begin
                errors++;
                $display("[TB] FAIL seq_fetch: pc=%h pt=%b flush=%b, expected pc=%h pt=0 flush=0",
                         bus.pc, bus.pred_taken, bus.flush, 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch_alloc();
        applyEx(1, 1, 0, 1, 32'h10, 32'h40, 0, 32'h0);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alloc_flush: got %b expected 1", bus.flush);
        end
        tick();
        checks++;
        if (bus.pc !== 32'h40) begin
            errors++;
            $display("[TB] FAIL alloc_pc: got %h expected 00000040", bus.pc);
        end
        idleEx();
        redirectTo(32'h10);
        checks++;
        if (bus.pc !== 32'h10 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h40) begin
            errors++;
            $display("[TB] FAIL alloc_predict: pc=%h pt=%b ptgt=%h, expected 10/1/40",
                     bus.pc, bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_not_taken_twice();
        applyEx(1, 1, 0, 0, 32'h10, 32'h40, 1, 32'h40);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nt1_flush: got %b expected 1", bus.flush);
        end
        tick();
        checks++;
        if (bus.pc !== 32'h14) begin
            errors++;
            $display("[TB] FAIL nt1_pc: got %h expected 00000014", bus.pc);
        end
        applyEx(1, 1, 0, 0, 32'h10, 32'h40, 0, 32'h14);
        checks++;
        if (bus.flush !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nt2_flush: got %b expected 0", bus.flush);
        end
        tick();
        idleEx();
        redirectTo(32'h10);
        checks++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h14) begin
            errors++;
            $display("[TB] FAIL nt_predict: pt=%b ptgt=%h, expected 0/14", bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_jalr_retarget();
        applyEx(1, 0, 1, 1, 32'h20, 32'h100, 0, 32'h0);
        tick();
        checks++;
        if (bus.pc !== 32'h100) begin
            errors++;
            $display("[TB] FAIL jalr_alloc_pc: got %h expected 00000100", bus.pc);
        end
        applyEx(1, 0, 1, 1, 32'h20, 32'h200, 1, 32'h100);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jalr_flush: got %b expected 1", bus.flush);
        end
        tick();
        checks++;
        if (bus.pc !== 32'h200) begin
            errors++;
            $display("[TB] FAIL jalr_pc: got %h expected 00000200", bus.pc);
        end
        idleEx();
        redirectTo(32'h20);
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h200) begin
            errors++;
            $display("[TB] FAIL jalr_predict: pt=%b ptgt=%h, expected 1/200", bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        applyEx(1, 1, 0, 1, 32'h64, 32'h80, 0, 32'h0);
        tick();
        checks++;
        if (bus.pc !== 32'h80) begin
            errors++;
            $display("[TB] FAIL stall_redirect: got %h expected 00000080", bus.pc);
        end
        idleEx();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.pc !== 32'h80) begin
                errors++;
                $display("[TB] FAIL stall_hold: got %h expected 00000080", bus.pc);
            end
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_alias();
        applyEx(1, 0, 1, 1, 32'h10, 32'h44, 0, 32'h0);
        tick();
        idleEx();
        redirectTo(32'h10);
        checks++;
        if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h44) begin
            errors++;
            $display("[TB] FAIL alias_setup: pt=%b ptgt=%h, expected 1/44", bus.pred_taken, bus.pred_target);
        end
        applyEx(1, 0, 0, 0, 32'h50, 32'h0, 1, 32'h44);
        checks++;
        if (bus.flush !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alias_flush: got %b expected 1", bus.flush);
        end
        tick();
        checks++;
        if (bus.pc !== 32'h54) begin
            errors++;
            $display("[TB] FAIL alias_pc: got %h expected 00000054", bus.pc);
        end
        idleEx();
        redirectTo(32'h10);
        checks++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h14) begin
            errors++;
            $display("[TB] FAIL alias_invalidate: pt=%b ptgt=%h, expected 0/14", bus.pred_taken, bus.pred_target);
        end
    endtask

    task automatic test_wrap_and_reset_priority();
        applyEx(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h40, 1, 32'h40);
        tick();
        checks++;
        if (bus.pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_pc: got %h expected 00000000", bus.pc);
        end
        idleEx();
        redirectTo(32'h20);
        applyEx(1, 0, 1, 1, 32'h20, 32'h300, 0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idleEx();
        checks++;
        if (bus.pc !== 32'h0 || bus.pred_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_priority: pc=%h pt=%b, expected 0/0", bus.pc, bus.pred_taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] pcs  [6] = '{32'h10, 32'h14, 32'h50, 32'h20, 32'h1010, 32'h0};
        logic [31:0] tgts [6] = '{32'h10, 32'h50, 32'h20, 32'h100, 32'h1010, 32'h14};
        int kind;
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom % 64) == 0;
            bus.stall = ($urandom % 4) == 0;
            kind      = int'($urandom % 4);
            applyEx($urandom % 2, kind == 1 || kind == 3, kind == 2, $urandom % 2,
                    pcs[$urandom % 6], tgts[$urandom % 6], $urandom % 2, tgts[$urandom % 6]);
            checks++;
            if (bus.pc !== mPc || bus.pred_taken !== expPredTaken() ||
                bus.pred_target !== expPredTarget() || bus.flush !== expMispredict()) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: pc=%h pt=%b ptgt=%h flush=%b, expected %h/%b/%h/%b",
                         n, bus.pc, bus.pred_taken, bus.pred_target, bus.flush,
                         mPc, expPredTaken(), expPredTarget(), expMispredict());
            end
            tick();
        end
        rst = 1'b0;
        bus.stall = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        modelReset();
        idleEx();
        test_reset();
        test_branch_alloc();
        test_not_taken_twice();
        test_jalr_retarget();
        test_stall();
        test_alias();
        test_wrap_and_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
